// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one host transaction at a time,
// framed as SETUP -> ACCESS (ACC_CYC cycles of CS) -> RECOVER -> IDLE.
module sram_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rws,
    output logic              sram_cs,
    inout  wire  [DATA_W-1:0] sram_io
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] ACCESS  = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic              rws_d;
    logic              cs_d;
    logic              ready_d;
    logic [DATA_W-1:0] rdata_d;
    logic              rvalid_d;

    // sram_rws doubles as the bus-drive enable, so a read can never see the controller driving
    assign sram_io = sram_rws ? wdata_q : {DATA_W{1'bz}};

    // next-state and next-output decode
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        wdata_d  = wdata_q;
        addr_d   = sram_addr;
        rws_d    = sram_rws;
        rdata_d  = rdata;
        rvalid_d = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    addr_d  = addr;
                    rws_d   = we;
                    wdata_d = wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    state_d = RECOVER;
                    if (!sram_rws) begin
                        rdata_d  = sram_io;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RECOVER: begin
                state_d = IDLE;
                rws_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rws_d   = 1'b0;
            end
        endcase
        ready_d = (state_d == IDLE);
        cs_d    = (state_d == ACCESS);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            sram_addr <= '0;
            sram_rws  <= 1'b0;
            sram_cs   <= 1'b0;
            ready     <= 1'b1;
            rdata     <= '0;
            rvalid    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wdata_q   <= wdata_d;
            sram_addr <= addr_d;
            sram_rws  <= rws_d;
            sram_cs   <= cs_d;
            ready     <= ready_d;
            rdata     <= rdata_d;
            rvalid    <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: ACC_CYC=4 instance under directed and random
// traffic, plus an ACC_CYC=1 instance for the short-access timing.
module tb_sram_ctrl;

    localparam int unsigned ACC   = 4;
    localparam int unsigned ACC_B = 1;

    typedef struct {
        bit         w;
        logic [9:0] a;
        logic [7:0] d;
        int         t;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       req, we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic       ready, rvalid, sram_rws, sram_cs;
    logic [7:0] rdata;
    logic [9:0] sram_addr;
    wire  [7:0] sram_io;
    logic [7:0] sram_mem [1024];

    logic       req_b, we_b;
    logic [9:0] addr_b;
    logic [7:0] wdata_b;
    logic       ready_b, rvalid_b, sram_rws_b, sram_cs_b;
    logic [7:0] rdata_b;
    logic [9:0] sram_addr_b;
    wire  [7:0] sram_io_b;
    logic [7:0] mem_b [1024];

    logic [7:0] ref_mem [1024];
    txn_t       exp_q[$];
    txn_t       tx;
    int         cs_run = 0;
    bit         prev_cs = 1'b0;
    bit         prev_ready = 1'b1;
    bit         exp_rv;
    int         last_t = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl #(.ADDR_W(10), .DATA_W(8), .ACC_CYC(ACC)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .sram_addr(sram_addr),
        .sram_rws(sram_rws), .sram_cs(sram_cs), .sram_io(sram_io)
    );

    sram_ctrl #(.ADDR_W(10), .DATA_W(8), .ACC_CYC(ACC_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b), .sram_addr(sram_addr_b),
        .sram_rws(sram_rws_b), .sram_cs(sram_cs_b), .sram_io(sram_io_b)
    );

    // asynchronous SRAM models: drive on CS read, capture on CS write
    assign sram_io   = (sram_cs && !sram_rws) ? sram_mem[sram_addr] : 8'hzz;
    assign sram_io_b = (sram_cs_b && !sram_rws_b) ? mem_b[sram_addr_b] : 8'hzz;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= 8'h5A;
        end else if (sram_cs && sram_rws) begin
            sram_mem[sram_addr] <= sram_io;
        end
    end

    always @(posedge clk) begin
        if (sram_cs_b && sram_rws_b) mem_b[sram_addr_b] <= sram_io_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pairs each CS window with the oldest issued transaction
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cs_run     = 0;
            prev_cs    = 1'b0;
            prev_ready = 1'b1;
        end else begin
            exp_rv = 1'b0;
            if (ready) check("idle_bus", 32'({sram_cs, sram_rws}), 32'd0);
            if (sram_cs && !prev_cs) begin
                cs_run = 1;
                check("q_depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    check("cs_start", 32'(cyc), 32'(exp_q[0].t + 1));
                    check("sram_addr", 32'(sram_addr), 32'(exp_q[0].a));
                    check("sram_rws", 32'(sram_rws), 32'(exp_q[0].w));
                end
            end else if (sram_cs) begin
                cs_run++;
            end else if (prev_cs) begin
                check("cs_width", 32'(cs_run), 32'(ACC));
                if (exp_q.size() != 0) begin
                    tx = exp_q.pop_front();
                    last_t = tx.t;
                    if (tx.w) begin
                        check("wr_mem", 32'(sram_mem[tx.a]), 32'(tx.d));
                    end else begin
                        exp_rv = 1'b1;
                        check("rdata", 32'(rdata), 32'(tx.d));
                    end
                end
            end
            check("rvalid", 32'(rvalid), 32'(exp_rv));
            if (ready && !prev_ready) check("ready_ret", 32'(cyc), 32'(last_t + 2 + int'(ACC)));
            prev_cs    = sram_cs;
            prev_ready = ready;
        end
    end

    // issue one request from a negedge; returns at the negedge after acceptance
    task automatic issue(input bit w, input logic [9:0] a, input logic [7:0] d,
                         input bit hold, input bit glitch);
        int n = 0;
        while (!ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(ready), 32'd1);
        if (!ready) return;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        exp_q.push_back('{w: w, a: a, d: (w ? d : ref_mem[a]), t: cyc});
        if (w) ref_mem[a] = d;
        if (!hold) req = 1'b0;
        if (glitch && !hold) begin
            req = 1'b1; we = ~w; addr = ~a; wdata = ~d;
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic run_b(input bit w, input logic [9:0] a, input logic [7:0] d,
                         output int rv_at, output int rdy_at, output int rv_n,
                         output logic [7:0] rd);
        int t;
        rv_at = -1; rdy_at = -1; rv_n = 0; rd = 8'h00;
        req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
        @(negedge clk);
        t = cyc;
        req_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rvalid_b) begin
                rv_n++;
                if (rv_at < 0) rv_at = cyc - t;
                rd = rdata_b;
            end
            if (ready_b && rdy_at < 0) rdy_at = cyc - t;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit         rw, rh, rg;
        logic [9:0] ra;
        logic [7:0] rdv;
        int         rv_at, rdy_at, rv_n;
        logic [7:0] rd;

        rst = 1'b1; preload = 1'b1;
        req = 1'b1; we = 1'b0; addr = 10'd0; wdata = 8'h33;
        req_b = 1'b0; we_b = 1'b0; addr_b = 10'd0; wdata_b = 8'h00;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_cs", 32'(sram_cs), 32'd0);
        check("rst_rws", 32'(sram_rws), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);

        // req held through reset: accepted on the first edge with rst low
        #1 rst = 1'b0; preload = 1'b0;
        exp_q.push_back('{w: 1'b0, a: 10'd0, d: 8'h5A, t: cyc + 1});
        @(negedge clk);
        req = 1'b0;

        issue(1'b1, 10'd10,   8'd100, 1'b1, 1'b0);
        issue(1'b1, 10'd20,   8'd200, 1'b1, 1'b0);
        issue(1'b1, 10'd1000, 8'd1,   1'b1, 1'b0);
        issue(1'b0, 10'd20,   8'd0,   1'b0, 1'b0);
        issue(1'b0, 10'd10,   8'd0,   1'b0, 1'b0);
        issue(1'b0, 10'd1000, 8'd0,   1'b0, 1'b0);

        // host changes and a stray req while busy must not disturb the write
        issue(1'b1, 10'd5, 8'h77, 1'b0, 1'b1);
        issue(1'b0, 10'd5, 8'h00, 1'b0, 1'b0);
        issue(1'b0, 10'd1018, 8'h00, 1'b0, 1'b0);

        // reset during the second ACCESS cycle of a read
        issue(1'b0, 10'd20, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(sram_cs), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_rvalid", 32'(rvalid), 32'd0);
        check("abort_rws", 32'(sram_rws), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 10'd20, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = 10'($urandom_range(0, 15));
            rdv = 8'($urandom);
            rh  = ($urandom_range(0, 3) == 0);
            rg  = ($urandom_range(0, 2) == 0);
            issue(rw, ra, rdv, rh, rg);
        end
        req = 1'b0;

        for (int i = 0; i < 30 && !(exp_q.size() == 0 && ready); i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        run_b(1'b1, 10'd1023, 8'hFF, rv_at, rdy_at, rv_n, rd);
        check("b_wr_ready_at", 32'(rdy_at), 32'd3);
        check("b_wr_rvalid_n", 32'(rv_n), 32'd0);
        run_b(1'b0, 10'd1023, 8'h00, rv_at, rdy_at, rv_n, rd);
        check("b_rd_rdata", 32'(rd), 32'hFF);
        check("b_rd_rvalid_at", 32'(rv_at), 32'd2);
        check("b_rd_ready_at", 32'(rdy_at), 32'd3);
        check("b_rd_rvalid_n", 32'(rv_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
